// File: rtl/weight_bin_classifier_if.sv
// Scale-side and reporting-side signals of the weight bin classifier.
// The total port exists only when PKG_TOTAL_EN is defined.
interface weight_bin_classifier_if #(
  parameter int W_WIDTH   = 12,
  parameter int NUM_GRP   = 6,
  parameter int CNT_WIDTH = 8
);
  logic [W_WIDTH-1:0]           weight;
  logic                         clr;
  logic                         thr_wr;
  logic [2:0]                   thr_idx;
  logic [W_WIDTH-1:0]           thr_data;
  logic [NUM_GRP*CNT_WIDTH-1:0] counts;
  logic [NUM_GRP-1:0]           sat;
  logic [2:0]                   cur_group;
  logic                         count_pulse;
`ifdef PKG_TOTAL_EN
  logic [15:0]                  total;

  modport master (
    output weight, clr, thr_wr, thr_idx, thr_data,
    input  counts, sat, cur_group, count_pulse, total
  );
  modport slave (
    input  weight, clr, thr_wr, thr_idx, thr_data,
    output counts, sat, cur_group, count_pulse, total
  );
`else
  modport master (
    output weight, clr, thr_wr, thr_idx, thr_data,
    input  counts, sat, cur_group, count_pulse
  );
  modport slave (
    input  weight, clr, thr_wr, thr_idx, thr_data,
    output counts, sat, cur_group, count_pulse
  );
`endif
endinterface

// File: rtl/weight_bin_classifier.sv
// Bins settled scale weights against programmable thresholds and counts each package once.
// cur_group lags weight by one cycle; PKG_TOTAL_EN adds a 16-bit wrapping package total.
module weight_bin_classifier #(
  parameter int W_WIDTH    = 12,
  parameter int NUM_GRP    = 6,
  parameter int CNT_WIDTH  = 8,
  parameter int SETTLE_CYC = 3,
  parameter logic [(NUM_GRP-1)*W_WIDTH-1:0] THR_INIT =
    {12'd2000, 12'd1500, 12'd750, 12'd500, 12'd250}
) (
  input logic                clk,
  input logic                reset,
  weight_bin_classifier_if.slave bus
);
  localparam int SCW = $clog2(SETTLE_CYC + 1);
  localparam logic [SCW-1:0]       STABLE_ONE = SCW'(1);
  localparam logic [SCW-1:0]       STABLE_TGT = SCW'(SETTLE_CYC);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_COUNT, ST_HOLD} state_e;

  state_e                                state_q, state_d;
  logic [W_WIDTH-1:0]                    sample_q, sample_d;
  logic [SCW-1:0]                        stable_q, stable_d;
  logic [2:0]                            cur_group_q;
  logic [NUM_GRP-2:0][W_WIDTH-1:0]       thr_q;
  logic [NUM_GRP-1:0][CNT_WIDTH-1:0]     counts_q;
  logic [NUM_GRP-1:0]                    sat_q;
  logic                                  count_en;
  logic [3:0]                            cur_bin;
  logic [3:0]                            cnt_bin;

  // First-match search: the lowest index whose threshold covers the weight wins,
  // so non-ascending tables still resolve deterministically.
  function automatic logic [3:0] bin_of(input logic [W_WIDTH-1:0] w,
                                        input logic [NUM_GRP-2:0][W_WIDTH-1:0] t);
    logic [3:0] b;
    b = 4'(NUM_GRP);
    for (int i = NUM_GRP - 2; i >= 0; i--) begin
      if (w <= t[i]) b = 4'(i + 1);
    end
    if (w == '0) b = '0;
    return b;
  endfunction

  assign cur_bin = bin_of(bus.weight, thr_q);
  assign cnt_bin = bin_of(sample_q, thr_q);

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    stable_d = stable_q;
    count_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.weight != '0) begin
          sample_d = bus.weight;
          stable_d = STABLE_ONE;
          state_d  = (SETTLE_CYC == 1) ? ST_COUNT : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (bus.weight == '0) begin
          state_d = ST_IDLE;
        end else if (bus.weight != sample_q) begin
          sample_d = bus.weight;
          stable_d = STABLE_ONE;
          state_d  = (SETTLE_CYC == 1) ? ST_COUNT : ST_SETTLE;
        end else begin
          stable_d = stable_q + STABLE_ONE;
          if (stable_d == STABLE_TGT) state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        count_en = 1'b1;
        state_d  = (bus.weight == '0) ? ST_IDLE : ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.weight == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sample_q    <= '0;
      stable_q    <= '0;
      cur_group_q <= '0;
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      stable_q    <= stable_d;
      cur_group_q <= cur_bin[2:0];
    end
  end

  // Writes land at the clock edge, so a count in the same cycle still sees the old table.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thr_q <= THR_INIT;
    end else begin
      for (int i = 0; i < NUM_GRP - 1; i++) begin
        if (bus.thr_wr && bus.thr_idx == 3'(i)) thr_q[i] <= bus.thr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counts_q <= '0;
      sat_q    <= '0;
    end else if (bus.clr) begin
      counts_q <= '0;
      sat_q    <= '0;
    end else if (count_en) begin
      for (int g = 0; g < NUM_GRP; g++) begin
        if (cnt_bin == 4'(g + 1)) begin
          if (counts_q[g] == '1) sat_q[g] <= 1'b1;
          else                   counts_q[g] <= counts_q[g] + CNT_ONE;
        end
      end
    end
  end

`ifdef PKG_TOTAL_EN
  logic [15:0] total_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         total_q <= '0;
    else if (bus.clr)  total_q <= '0;
    else if (count_en) total_q <= total_q + 16'd1;
  end

  assign bus.total = total_q;
`endif

  assign bus.counts      = counts_q;
  assign bus.sat         = sat_q;
  assign bus.cur_group   = cur_group_q;
  assign bus.count_pulse = (state_q == ST_COUNT);
endmodule

// File: tb/tb_weight_bin_classifier.sv
module tb_weight_bin_classifier;
  localparam int W  = 12;
  localparam int NG = 6;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  weight_bin_classifier_if #(.W_WIDTH(W), .NUM_GRP(NG), .CNT_WIDTH(CW)) bus ();

  weight_bin_classifier #(
    .W_WIDTH(W), .NUM_GRP(NG), .CNT_WIDTH(CW), .SETTLE_CYC(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [NG*CW-1:0] counts;
    logic [NG-1:0]    sat;
    logic [15:0]      total;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          mdl_cnt[NG];
  logic [NG-1:0] mdl_sat;
  logic [15:0] mdl_total;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NG*CW-1:0] pack_cnt();
    logic [NG*CW-1:0] v;
    v = '0;
    for (int g = 0; g < NG; g++) v[g*CW +: CW] = CW'(mdl_cnt[g]);
    return v;
  endfunction

  task automatic mdl_clear();
    for (int g = 0; g < NG; g++) mdl_cnt[g] = 0;
    mdl_sat   = '0;
    mdl_total = '0;
  endtask

  // Queue the state expected once the package with the given bin has been counted.
  task automatic expect_pkg(input int bin, input bit clr_same);
    exp_t e;
    if (clr_same) begin
      mdl_clear();
    end else begin
      if (mdl_cnt[bin-1] == (1 << CW) - 1) mdl_sat[bin-1] = 1'b1;
      else                                 mdl_cnt[bin-1]++;
      mdl_total++;
    end
    e.counts = pack_cnt();
    e.sat    = mdl_sat;
    e.total  = mdl_total;
    exp_q.push_back(e);
  endtask

  task automatic pkg(input logic [W-1:0] w, input int hold);
    bus.weight = w;
    repeat (hold) step();
    bus.weight = '0;
    repeat (2) step();
  endtask

  task automatic clr_pulse();
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    mdl_clear();
  endtask

  // Monitor: every count_pulse must match a queued expectation, checked once the counters update.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && bus.count_pulse === 1'b1) begin
        check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          @(negedge clk);
          check("counts", 32'(bus.counts), 32'(e.counts));
          check("sat", 32'(bus.sat), 32'(e.sat));
`ifdef PKG_TOTAL_EN
          check("total", 32'(bus.total), 32'(e.total));
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    bus.weight   = '0;
    bus.clr      = 1'b0;
    bus.thr_wr   = 1'b0;
    bus.thr_idx  = '0;
    bus.thr_data = '0;
    mdl_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    step();

    check("rst_counts", 32'(bus.counts), 32'd0);
    check("rst_sat", 32'(bus.sat), 32'd0);
    check("rst_cur_group", 32'(bus.cur_group), 32'd0);
    check("rst_pulse", 32'(bus.count_pulse), 32'd0);

    // 300 held three samples -> bin 2, cur_group follows weight by one cycle
    expect_pkg(2, 1'b0);
    bus.weight = 12'd300;
    step();
    check("cur_group_300", 32'(bus.cur_group), 32'd2);
    repeat (2) step();
    bus.weight = '0;
    step();
    check("cur_group_empty", 32'(bus.cur_group), 32'd0);
    repeat (2) step();

    // Change during settling restarts the count; only 800 (bin 4) is counted
    expect_pkg(4, 1'b0);
    bus.weight = 12'd300;
    step();
    bus.weight = 12'd800;
    repeat (3) step();
    bus.weight = '0;
    repeat (2) step();

    // Long hold then change without emptying: single count in bin 1
    expect_pkg(1, 1'b0);
    bus.weight = 12'd100;
    repeat (20) step();
    bus.weight = 12'd1900;
    repeat (5) step();
    check("cur_group_1900", 32'(bus.cur_group), 32'd5);
    bus.weight = '0;
    repeat (2) step();

    // Saturation of bin 6 with 2-bit counters, then clear
    clr_pulse();
    check("clr_counts", 32'(bus.counts), 32'd0);
    for (int k = 0; k < 4; k++) begin
      expect_pkg(6, 1'b0);
      pkg(12'd2500, 3);
    end
    check("sat_bin6", 32'(bus.sat), 32'h20);
    clr_pulse();
    check("clr2_counts", 32'(bus.counts), 32'd0);
    check("clr2_sat", 32'(bus.sat), 32'd0);

    // clr in the COUNT cycle: pulse still fires, counts end at zero
    expect_pkg(1, 1'b0);
    pkg(12'd100, 3);
    bus.weight = 12'd900;
    repeat (3) step();
    bus.clr = 1'b1;
    expect_pkg(4, 1'b1);
    step();
    bus.clr    = 1'b0;
    bus.weight = '0;
    repeat (2) step();

    // Threshold 0 lowered to 50: 100 moves to bin 2
    bus.thr_wr   = 1'b1;
    bus.thr_idx  = 3'd0;
    bus.thr_data = 12'd50;
    step();
    bus.thr_wr = 1'b0;
    expect_pkg(2, 1'b0);
    pkg(12'd100, 3);

    // Out-of-range index ignored: 600 stays in bin 3
    bus.thr_wr   = 1'b1;
    bus.thr_idx  = 3'd5;
    bus.thr_data = 12'd1;
    step();
    bus.thr_idx = 3'd7;
    step();
    bus.thr_wr = 1'b0;
    expect_pkg(3, 1'b0);
    pkg(12'd600, 3);

    // Write coinciding with COUNT uses the old threshold (50 -> bin 2), then new (150 -> bin 1)
    bus.weight = 12'd100;
    repeat (3) step();
    bus.thr_wr   = 1'b1;
    bus.thr_idx  = 3'd0;
    bus.thr_data = 12'd150;
    expect_pkg(2, 1'b0);
    step();
    bus.thr_wr = 1'b0;
    bus.weight = '0;
    repeat (2) step();
    expect_pkg(1, 1'b0);
    pkg(12'd100, 3);

    // Asynchronous reset while settling
    bus.weight = 12'd700;
    repeat (2) step();
    check("cur_group_700", 32'(bus.cur_group), 32'd3);
    #1 reset = 1'b1;
    #1;
    check("arst_counts", 32'(bus.counts), 32'd0);
    check("arst_sat", 32'(bus.sat), 32'd0);
    check("arst_cur_group", 32'(bus.cur_group), 32'd0);
    check("arst_pulse", 32'(bus.count_pulse), 32'd0);
`ifdef PKG_TOTAL_EN
    check("arst_total", 32'(bus.total), 32'd0);
`endif
    mdl_clear();
    repeat (2) step();
    reset = 1'b0;
    // Package still on the scale after release is counted once
    expect_pkg(3, 1'b0);
    repeat (5) step();
    bus.weight = '0;
    repeat (2) step();
    // Thresholds back at reset values: 200 -> bin 1
    expect_pkg(1, 1'b0);
    pkg(12'd200, 3);

    repeat (3) step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
